clint_timer: RTL

Parametrised machine-timer block for the SoC peripheral bus: one 64-bit free-running `mtime` counter with a programmable prescaler and enable, plus `NUM_CMP` independent 64-bit `mtimecmp` comparators, each driving its own level interrupt. It provides a coherent 64-bit `mtime` read through a high-word snapshot, byte-lane writes, and a registered read response. It sits on the same bus slot as the existing machine timer and drives per-hart / per-source timer interrupt lines.

---
 rtl/clint_timer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - machine timer: prescaled 64-bit mtime plus NUM_CMP mtimecmp comparators
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   timer_req_i            single-cycle bus request
//   timer_we_i             1 = write, 0 = read
//   timer_sel_i[3:0]       write byte enables
//   timer_addr_i[31:0]     byte address, only [9:0] decoded
//   timer_wdata_i[31:0]    write data
//   timer_rvalid_o         read response pulse, one cycle after a read request
//   timer_rdata_o[31:0]    read data, held between responses
//   timer_intr_o[NUM_CMP]  per-comparator level interrupt (mtime >= mtimecmp[i])
module clint_timer #(
  parameter int NUM_CMP    = 2,
  parameter int PRESCALE_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               timer_req_i,
  input  logic [3:0]         timer_sel_i,
  input  logic [31:0]        timer_addr_i,
  input  logic               timer_we_i,
  input  logic [31:0]        timer_wdata_i,
  output logic               timer_rvalid_o,
  output logic [31:0]        timer_rdata_o,
  output logic [NUM_CMP-1:0] timer_intr_o
);

  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q [NUM_CMP];
  logic [63:0]           cmp_d [NUM_CMP];
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]           snap_q, snap_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [NUM_CMP-1:0]    intr_q, intr_d;

  // Address decode: word-aligned offsets only; misaligned addresses are unmapped.
  logic [7:0] word;
  logic       aligned;
  logic       wr, rd;
  logic       sel_lo, sel_hi, sel_ctrl, sel_pre, sel_cmp;
  logic [6:0] cmp_idx;
  logic       cmp_hi;

  assign word     = timer_addr_i[9:2];
  assign aligned  = (timer_addr_i[1:0] == 2'b00);
  assign wr       = timer_req_i & timer_we_i;
  assign rd       = timer_req_i & ~timer_we_i;
  assign sel_lo   = aligned && (word == 8'd0);
  assign sel_hi   = aligned && (word == 8'd1);
  assign sel_ctrl = aligned && (word == 8'd2);
  assign sel_pre  = aligned && (word == 8'd3);
  // Comparator i occupies words 4+2i (LO) and 5+2i (HI).
  assign cmp_idx  = word[7:1] - 7'd2;
  assign cmp_hi   = word[0];
  assign sel_cmp  = aligned && (word >= 8'd4) && (cmp_idx < 7'(NUM_CMP));

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic        pcnt_clr;
  logic        pcnt_wrap;
  logic        tick;
  logic [31:0] pre_merged;
  logic [31:0] rd_val;

  always_comb begin
    pcnt_clr   = wr & (sel_ctrl | sel_pre);
    pcnt_wrap  = (pcnt_q == prescale_q);
    // A CTRL/PRESCALE write restarts the prescaler and swallows a pending tick.
    tick       = en_q & pcnt_wrap & ~pcnt_clr;
    pre_merged = merge(32'(prescale_q), timer_wdata_i, timer_sel_i);

    pcnt_d = pcnt_q;
    if (pcnt_clr) begin
      pcnt_d = '0;
    end else if (en_q) begin
      pcnt_d = pcnt_wrap ? '0 : pcnt_q + PRESCALE_W'(1);
    end

    // A direct mtime write takes priority over the tick so the written value lands exactly.
    mtime_d = mtime_q;
    if (wr && sel_lo) begin
      mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], timer_wdata_i, timer_sel_i)};
    end else if (wr && sel_hi) begin
      mtime_d = {merge(mtime_q[63:32], timer_wdata_i, timer_sel_i), mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    en_d = en_q;
    if (wr && sel_ctrl && timer_sel_i[0]) en_d = timer_wdata_i[0];

    prescale_d = prescale_q;
    if (wr && sel_pre) prescale_d = pre_merged[PRESCALE_W-1:0];

    rd_val = 32'd0;
    if (sel_lo)   rd_val = mtime_q[31:0];
    if (sel_hi)   rd_val = snap_q;
    if (sel_ctrl) rd_val = {31'd0, en_q};
    if (sel_pre)  rd_val = 32'(prescale_q);

    for (int i = 0; i < NUM_CMP; i++) begin
      cmp_d[i]  = cmp_q[i];
      intr_d[i] = (mtime_q >= cmp_q[i]);
      if (sel_cmp && (cmp_idx == 7'(i))) begin
        if (cmp_hi) rd_val = cmp_q[i][63:32];
        else        rd_val = cmp_q[i][31:0];
        if (wr) begin
          // Writing either half of a comparator masks its interrupt for one cycle.
          intr_d[i] = 1'b0;
          if (cmp_hi) cmp_d[i][63:32] = merge(cmp_q[i][63:32], timer_wdata_i, timer_sel_i);
          else        cmp_d[i][31:0]  = merge(cmp_q[i][31:0],  timer_wdata_i, timer_sel_i);
        end
      end
    end

    // Reading LO captures the live HI word so a following HI read is coherent.
    snap_d   = (rd && sel_lo) ? mtime_q[63:32] : snap_q;
    rvalid_d = rd;
    rdata_d  = rd ? rd_val : rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      en_q       <= 1'b1;
      prescale_q <= '0;
      pcnt_q     <= '0;
      snap_q     <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      intr_q     <= '0;
      for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= '1;
    end else begin
      mtime_q    <= mtime_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      snap_q     <= snap_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      intr_q     <= intr_d;
      for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  assign timer_rvalid_o = rvalid_q;
  assign timer_rdata_o  = rdata_q;
  assign timer_intr_o   = intr_q;

endmodule
